// File: rtl/fetch_stage_ctrl.sv
// IF-stage controller: PC register, single-outstanding imem handshake, IF/ID register.
// Zero-wait memory gives one instruction per cycle; stalls park the fetched word in a hold buffer with Req dropped.
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_Stall,
   input  logic        IF_ID_Stall,
   input  logic        IF_ID_Flush,
   input  logic        Redirect_Valid,
   input  logic [31:0] Redirect_PC,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ack,
   input  logic [31:0] IMem_Data,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid
);

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_hold_instr;
   logic [31:0] r_hold_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pcplus4;
   logic        r_ifid_valid;

   logic        w_stall;
   logic        w_redir;
   logic        w_i_valid;
   logic [31:0] w_i_instr;
   logic [31:0] w_i_pc;
   logic [31:0] w_i_pcplus4;
   logic [31:0] w_redir_pc;
   logic        w_deliver;

   assign w_stall     = PC_Stall | IF_ID_Stall;
   assign w_redir     = Redirect_Valid & ~PC_Stall;
   assign w_redir_pc  = Redirect_PC & 32'hFFFF_FFFC;
   assign w_i_pcplus4 = w_i_pc + 32'd4;

   always_comb begin
      w_i_valid = (r_state == S_HOLD) ||
                  (IMem_Ack && ((r_state == S_ISSUE) || (r_state == S_WAIT)));
      w_i_instr = (r_state == S_HOLD) ? r_hold_instr : IMem_Data;
      case (r_state)
         S_HOLD:  w_i_pc = r_hold_pc;
         S_ISSUE: w_i_pc = r_pc;
         default: w_i_pc = r_req_addr;
      endcase
      w_deliver = w_i_valid & ~w_redir & ~w_stall & ~IF_ID_Flush;
   end

   // Request address is the live PC only in ISSUE; afterwards it is frozen until the Ack.
   assign IMem_Req      = (r_state != S_HOLD);
   assign IMem_Addr     = (r_state == S_ISSUE) ? r_pc : r_req_addr;
   assign PC            = r_pc;
   assign IF_ID_Instr   = r_ifid_instr;
   assign IF_ID_PCPlus4 = r_ifid_pcplus4;
   assign IF_ID_Valid   = r_ifid_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_ISSUE;
         r_pc         <= RESET_PC;
         r_req_addr   <= RESET_PC;
         r_hold_instr <= 32'd0;
         r_hold_pc    <= 32'd0;
      end else if (w_i_valid) begin
         if (w_redir) begin
            r_pc    <= w_redir_pc;
            r_state <= S_ISSUE;
         end else if (w_stall || IF_ID_Flush) begin
            if (r_state != S_HOLD) begin
               r_hold_instr <= w_i_instr;
               r_hold_pc    <= w_i_pc;
            end
            r_state <= S_HOLD;
         end else begin
            r_pc    <= w_i_pcplus4;
            r_state <= S_ISSUE;
         end
      end else begin
         if (w_redir) begin
            r_pc <= w_redir_pc;
         end
         // A redirect with a request in flight must drain that response before reissuing.
         case (r_state)
            S_ISSUE: begin
               r_req_addr <= r_pc;
               r_state    <= w_redir ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
               if (w_redir) begin
                  r_state <= S_DROP;
               end
            end
            S_DROP: begin
               if (IMem_Ack) begin
                  r_state <= S_ISSUE;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ifid_instr   <= 32'd0;
         r_ifid_pcplus4 <= 32'd0;
         r_ifid_valid   <= 1'b0;
      end else if (IF_ID_Flush) begin
         r_ifid_instr   <= 32'd0;
         r_ifid_pcplus4 <= 32'd0;
         r_ifid_valid   <= 1'b0;
      end else if (IF_ID_Stall) begin
         r_ifid_instr   <= r_ifid_instr;
         r_ifid_pcplus4 <= r_ifid_pcplus4;
         r_ifid_valid   <= r_ifid_valid;
      end else if (w_deliver) begin
         r_ifid_instr   <= w_i_instr;
         r_ifid_pcplus4 <= w_i_pcplus4;
         r_ifid_valid   <= 1'b1;
      end else begin
         r_ifid_instr   <= 32'd0;
         r_ifid_pcplus4 <= 32'd0;
         r_ifid_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: scoreboard of expected IF/ID loads, checked each edge.
module tb_fetch_stage_ctrl;

   logic        clk;
   logic        reset;
   logic        PC_Stall;
   logic        IF_ID_Stall;
   logic        IF_ID_Flush;
   logic        Redirect_Valid;
   logic [31:0] Redirect_PC;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ack;
   logic [31:0] IMem_Data;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;

   logic        mirror;
   logic [31:0] d_val;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t        exp_q[$];
   int          n_total;
   int          n_bad;
   logic        last_vld;
   logic [31:0] last_instr;
   logic [31:0] last_pc4;

   // Memory model: either echoes the address as data or returns a chosen word.
   assign IMem_Data = mirror ? IMem_Addr : d_val;

   fetch_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut (
      .clk            (clk),
      .reset          (reset),
      .PC_Stall       (PC_Stall),
      .IF_ID_Stall    (IF_ID_Stall),
      .IF_ID_Flush    (IF_ID_Flush),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .IMem_Req       (IMem_Req),
      .IMem_Addr      (IMem_Addr),
      .IMem_Ack       (IMem_Ack),
      .IMem_Data      (IMem_Data),
      .PC             (PC),
      .IF_ID_Instr    (IF_ID_Instr),
      .IF_ID_PCPlus4  (IF_ID_PCPlus4),
      .IF_ID_Valid    (IF_ID_Valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
      exp_t e;
      e.instr = instr;
      e.pc4   = pc4;
      exp_q.push_back(e);
   endtask

   // One clock edge, then compare IF/ID against hold / scoreboard entry / bubble.
   task automatic cyc();
      logic h;
      exp_t e;
      h = IF_ID_Stall & ~IF_ID_Flush;
      @(posedge clk);
      #1;
      if (h) begin
         chk("ifid_hold_vld",   {31'd0, IF_ID_Valid}, {31'd0, last_vld});
         chk("ifid_hold_instr", IF_ID_Instr, last_instr);
         chk("ifid_hold_pc4",   IF_ID_PCPlus4, last_pc4);
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("ifid_vld",   {31'd0, IF_ID_Valid}, 32'd1);
         chk("ifid_instr", IF_ID_Instr, e.instr);
         chk("ifid_pc4",   IF_ID_PCPlus4, e.pc4);
         last_vld   = 1'b1;
         last_instr = e.instr;
         last_pc4   = e.pc4;
      end else begin
         chk("bubble_vld",   {31'd0, IF_ID_Valid}, 32'd0);
         chk("bubble_instr", IF_ID_Instr, 32'd0);
         chk("bubble_pc4",   IF_ID_PCPlus4, 32'd0);
         last_vld   = 1'b0;
         last_instr = 32'd0;
         last_pc4   = 32'd0;
      end
   endtask

   initial begin
      n_total = 0;
      n_bad = 0;
      last_vld = 1'b0;
      last_instr = 32'd0;
      last_pc4 = 32'd0;
      reset = 1'b1;
      PC_Stall = 1'b0;
      IF_ID_Stall = 1'b0;
      IF_ID_Flush = 1'b0;
      Redirect_Valid = 1'b0;
      Redirect_PC = 32'd0;
      IMem_Ack = 1'b0;
      mirror = 1'b0;
      d_val = 32'd0;
      #1;
      chk("rst_pc",    PC, 32'hFFFF_FFFC);
      chk("rst_vld",   {31'd0, IF_ID_Valid}, 32'd0);
      chk("rst_instr", IF_ID_Instr, 32'd0);
      chk("rst_pc4",   IF_ID_PCPlus4, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Zero-wait stream starting at the top of the address space.
      mirror = 1'b1;
      IMem_Ack = 1'b1;
      chk("rel_req",  {31'd0, IMem_Req}, 32'd1);
      chk("rel_addr", IMem_Addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC, 32'd0);
      cyc();
      chk("wrap_addr", IMem_Addr, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("stream_addr", IMem_Addr, 32'(i * 4));
         push(32'(i * 4), 32'(i * 4 + 4));
         cyc();
      end

      // Three-cycle memory latency at 0x0C.
      mirror = 1'b0;
      IMem_Ack = 1'b0;
      d_val = 32'hDEAD_0000;
      for (int i = 0; i < 2; i++) begin
         chk("lat_addr", IMem_Addr, 32'h0000_000C);
         chk("lat_req",  {31'd0, IMem_Req}, 32'd1);
         cyc();
      end
      chk("lat_addr3", IMem_Addr, 32'h0000_000C);
      IMem_Ack = 1'b1;
      d_val = 32'hA5A5_000C;
      push(32'hA5A5_000C, 32'h0000_0010);
      cyc();
      IMem_Ack = 1'b0;
      chk("lat_next_addr", IMem_Addr, 32'h0000_0010);
      chk("lat_next_pc",   PC, 32'h0000_0010);

      // Stall in the Ack cycle: word parked, Req dropped, delivered after release.
      IMem_Ack = 1'b1;
      d_val = 32'hD000_0010;
      PC_Stall = 1'b1;
      IF_ID_Stall = 1'b1;
      cyc();
      IMem_Ack = 1'b0;
      d_val = 32'hBAD0_0010;
      chk("hold_req1", {31'd0, IMem_Req}, 32'd0);
      chk("hold_pc",   PC, 32'h0000_0010);
      cyc();
      chk("hold_req2", {31'd0, IMem_Req}, 32'd0);
      PC_Stall = 1'b0;
      IF_ID_Stall = 1'b0;
      push(32'hD000_0010, 32'h0000_0014);
      cyc();
      chk("post_hold_req",  {31'd0, IMem_Req}, 32'd1);
      chk("post_hold_addr", IMem_Addr, 32'h0000_0014);

      // Redirect while a request is pending: response drained, never delivered.
      cyc();
      chk("wait_addr", IMem_Addr, 32'h0000_0014);
      Redirect_Valid = 1'b1;
      Redirect_PC = 32'h0000_0100;
      cyc();
      Redirect_Valid = 1'b0;
      chk("drop_pc",   PC, 32'h0000_0100);
      chk("drop_addr", IMem_Addr, 32'h0000_0014);
      chk("drop_req",  {31'd0, IMem_Req}, 32'd1);
      cyc();
      chk("drop_addr2", IMem_Addr, 32'h0000_0014);
      IMem_Ack = 1'b1;
      d_val = 32'hBAD0_0014;
      cyc();
      IMem_Ack = 1'b0;
      chk("after_drop_addr", IMem_Addr, 32'h0000_0100);
      chk("after_drop_req",  {31'd0, IMem_Req}, 32'd1);

      // Flush plus redirect with Ack: bubble, low bits of target cleared.
      IF_ID_Flush = 1'b1;
      Redirect_Valid = 1'b1;
      Redirect_PC = 32'h0000_0203;
      IMem_Ack = 1'b1;
      d_val = 32'hBAD0_0100;
      cyc();
      IF_ID_Flush = 1'b0;
      Redirect_Valid = 1'b0;
      chk("flush_redir_pc",   PC, 32'h0000_0200);
      chk("flush_redir_addr", IMem_Addr, 32'h0000_0200);
      mirror = 1'b1;
      push(32'h0000_0200, 32'h0000_0204);
      cyc();

      // Flush beats stall on the IF/ID register.
      IMem_Ack = 1'b0;
      IF_ID_Flush = 1'b1;
      IF_ID_Stall = 1'b1;
      PC_Stall = 1'b1;
      cyc();
      IF_ID_Flush = 1'b0;
      IF_ID_Stall = 1'b0;
      PC_Stall = 1'b0;
      chk("fbs_addr", IMem_Addr, 32'h0000_0204);

      // Redirect and Ack together in WAIT: straight to ISSUE at the target.
      Redirect_Valid = 1'b1;
      Redirect_PC = 32'h0000_0300;
      IMem_Ack = 1'b1;
      mirror = 1'b0;
      d_val = 32'hBAD0_0204;
      cyc();
      Redirect_Valid = 1'b0;
      chk("wr_ack_addr", IMem_Addr, 32'h0000_0300);
      chk("wr_ack_pc",   PC, 32'h0000_0300);
      mirror = 1'b1;
      push(32'h0000_0300, 32'h0000_0304);
      cyc();

      // Async reset between edges while WAIT holds a valid IF/ID entry.
      IMem_Ack = 1'b0;
      IF_ID_Stall = 1'b1;
      cyc();
      IF_ID_Stall = 1'b0;
      chk("pre_rst_addr", IMem_Addr, 32'h0000_0304);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_pc",    PC, 32'hFFFF_FFFC);
      chk("arst_vld",   {31'd0, IF_ID_Valid}, 32'd0);
      chk("arst_instr", IF_ID_Instr, 32'd0);
      chk("arst_pc4",   IF_ID_PCPlus4, 32'd0);
      chk("arst_addr",  IMem_Addr, 32'hFFFF_FFFC);
      last_vld = 1'b0;
      last_instr = 32'd0;
      last_pc4 = 32'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mirror = 1'b1;
      IMem_Ack = 1'b1;
      push(32'hFFFF_FFFC, 32'd0);
      cyc();
      IMem_Ack = 1'b0;
      chk("arst_wrap_addr", IMem_Addr, 32'd0);
      chk("arst_wrap_pc",   PC, 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
